// File: rtl/ifetch_prefetch_pkg.sv
// Shared types and constants for the prefetching instruction-fetch front end.
package ifetch_pkg;

  localparam logic [31:0] EXC_INSTR_MISALIGNED   = 32'd0;
  localparam logic [31:0] EXC_INSTR_ACCESS_FAULT = 32'd1;
  localparam logic [1:0]  AXI_RESP_OKAY          = 2'b00;
  localparam logic [2:0]  IMEM_ARPROT            = 3'b110;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
    logic        exc_pend;
    logic [31:0] exc_cause;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_prefetch_sync_fifo.sv
// Synchronous FIFO with clear and occupancy count; head is read combinationally
// from registered storage, so a push is only visible on the following cycle.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [AW:0]      count_o,
  output logic             empty_o,
  output logic             full_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW + 1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A pop frees the slot the same cycle, so push at full is fine alongside it.
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !clr_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ifetch_prefetch.sv
// Instruction fetch with multiple outstanding AXI4-Lite reads and a prefetch buffer.
// Optional `IFETCH_PERF_CNT_EN adds fetch/stall/discard performance counters.
module ifetch_prefetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR      = 32'h0000_0000,
  parameter int          MAX_OUTSTANDING = 2,
  parameter int          FIFO_DEPTH      = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        valid_out,
  input  logic        ready_in,
  input  logic        flush_in,
  output logic [31:0] imem_axi_araddr,
  output logic [2:0]  imem_axi_arprot,
  output logic        imem_axi_arvalid,
  input  logic        imem_axi_arready,
  input  logic [31:0] imem_axi_rdata,
  input  logic [1:0]  imem_axi_rresp,
  input  logic        imem_axi_rvalid,
  output logic        imem_axi_rready,
  output logic [31:0] PC_IF,
  output logic [31:0] IR_IF,
  output logic        exc_pend_IF,
  output logic [31:0] exc_cause_IF,
  input  logic        jump_mpred_EX,
  input  logic [31:0] jump_addr_EX,
  input  logic        trap_taken_csr,
  input  logic [31:0] trap_addr_csr
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_discard_cnt
`endif
);

  localparam int FAW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = FAW + 1;
  localparam int OW  = 4;

  logic          arvalid_q, arvalid_d, stale_ar_q, stale_ar_d;
  logic [31:0]   araddr_q, araddr_d, fetch_pc_q, fetch_pc_d, target;
  logic [OW-1:0] outstanding_q, outstanding_d, discard_q, discard_d;
  logic          mis_pend_q, mis_pend_d, halt_q, halt_d;
  logic          ar_hs, r_hs, pop, redirect, deliver, mis_push, entry_push, issue_ok;
  logic [CW-1:0] fifo_count, count_next, pcq_count;
  logic          fifo_empty, fifo_full, pcq_empty, pcq_full;
  logic [31:0]   pcq_head;
  fetch_entry_t  push_entry, head_entry;
  logic          unused_sigs;

  assign imem_axi_rready  = !reset;
  assign imem_axi_arvalid = arvalid_q;
  assign imem_axi_araddr  = araddr_q;
  assign imem_axi_arprot  = IMEM_ARPROT;
  assign ar_hs     = arvalid_q && imem_axi_arready;
  assign r_hs      = imem_axi_rvalid && imem_axi_rready;
  assign valid_out = !fifo_empty;
  assign pop       = valid_out && ready_in;
  assign redirect  = trap_taken_csr || jump_mpred_EX || flush_in;
  assign deliver   = r_hs && (discard_q == '0);
  assign mis_push  = mis_pend_q && (discard_q == '0);
  assign entry_push = deliver || mis_push;

  assign PC_IF        = valid_out ? head_entry.pc        : 32'd0;
  assign IR_IF        = valid_out ? head_entry.ir        : 32'd0;
  assign exc_pend_IF  = valid_out ? head_entry.exc_pend  : 1'b0;
  assign exc_cause_IF = valid_out ? head_entry.exc_cause : 32'd0;
  assign unused_sigs  = ^{pcq_count, pcq_empty, pcq_full, fifo_full};

  always_comb begin
    target = fetch_pc_q;
    if (trap_taken_csr)     target = trap_addr_csr;
    else if (jump_mpred_EX) target = jump_addr_EX;
    else if (!fifo_empty)   target = head_entry.pc;

    push_entry.pc        = pcq_head;
    push_entry.exc_pend  = (imem_axi_rresp != AXI_RESP_OKAY);
    push_entry.ir        = push_entry.exc_pend ? 32'd0 : imem_axi_rdata;
    push_entry.exc_cause = push_entry.exc_pend ? EXC_INSTR_ACCESS_FAULT : 32'd0;
    if (mis_push) begin
      push_entry.pc        = fetch_pc_q;
      push_entry.ir        = 32'd0;
      push_entry.exc_pend  = 1'b1;
      push_entry.exc_cause = EXC_INSTR_MISALIGNED;
    end

    count_next = fifo_count;
    if (entry_push && !pop)      count_next = fifo_count + CW'(1);
    else if (!entry_push && pop) count_next = fifo_count - CW'(1);
    if (redirect)                count_next = '0;

    outstanding_d = outstanding_q;
    if (ar_hs && !r_hs)      outstanding_d = outstanding_q + OW'(1);
    else if (!ar_hs && r_hs) outstanding_d = outstanding_q - OW'(1);

    // Everything still in flight (including an AR not yet accepted) is stale.
    discard_d = discard_q;
    if (r_hs && discard_q != '0) discard_d = discard_q - OW'(1);
    if (redirect) discard_d = outstanding_d + OW'(arvalid_q && !ar_hs);

    mis_pend_d = mis_pend_q;
    halt_d     = halt_q;
    if (mis_push) begin
      mis_pend_d = 1'b0;
      halt_d     = 1'b1;
    end
    if (redirect) begin
      mis_pend_d = (target[1:0] != 2'b00);
      halt_d     = 1'b0;
    end

    fetch_pc_d = fetch_pc_q;
    if (redirect)                  fetch_pc_d = target;
    else if (ar_hs && !stale_ar_q) fetch_pc_d = fetch_pc_q + 32'd4;

    issue_ok = !mis_pend_d && !halt_d &&
               (32'(outstanding_d) + 32'(count_next) < 32'(FIFO_DEPTH)) &&
               (32'(outstanding_d) < 32'(MAX_OUTSTANDING));

    arvalid_d  = 1'b0;
    araddr_d   = araddr_q;
    stale_ar_d = stale_ar_q;
    if (arvalid_q && !ar_hs) begin
      arvalid_d = 1'b1;
      if (redirect) stale_ar_d = 1'b1;
    end else if (ar_hs && stale_ar_q) begin
      stale_ar_d = 1'b0;
    end else if (!redirect && issue_ok) begin
      arvalid_d = 1'b1;
      araddr_d  = fetch_pc_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arvalid_q     <= 1'b0;
      araddr_q      <= RESET_ADDR;
      fetch_pc_q    <= RESET_ADDR;
      outstanding_q <= '0;
      discard_q     <= '0;
      stale_ar_q    <= 1'b0;
      mis_pend_q    <= 1'b0;
      halt_q        <= 1'b0;
    end else begin
      arvalid_q     <= arvalid_d;
      araddr_q      <= araddr_d;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      stale_ar_q    <= stale_ar_d;
      mis_pend_q    <= mis_pend_d;
      halt_q        <= halt_d;
    end
  end

  sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(FIFO_DEPTH)) u_entry_fifo (
    .clk_i(clk), .rst_i(reset), .clr_i(redirect),
    .push_i(entry_push), .wdata_i(push_entry), .pop_i(pop),
    .rdata_o(head_entry), .count_o(fifo_count), .empty_o(fifo_empty), .full_o(fifo_full)
  );

  // Addresses of every accepted AR, popped by every R beat (kept or dropped).
  sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_pc_queue (
    .clk_i(clk), .rst_i(reset), .clr_i(1'b0),
    .push_i(ar_hs), .wdata_i(araddr_q), .pop_i(r_hs),
    .rdata_o(pcq_head), .count_o(pcq_count), .empty_o(pcq_empty), .full_o(pcq_full)
  );

`ifdef IFETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetch_cnt   <= 32'd0;
      perf_stall_cnt   <= 32'd0;
      perf_discard_cnt <= 32'd0;
    end else begin
      if (pop)                         perf_fetch_cnt   <= perf_fetch_cnt + 32'd1;
      if (ready_in && !valid_out)      perf_stall_cnt   <= perf_stall_cnt + 32'd1;
      if (r_hs && discard_q != '0)     perf_discard_cnt <= perf_discard_cnt + 32'd1;
    end
  end
`endif

endmodule
